// File: rtl/sprite_register_queue_pkg.sv
// Shared definitions for the sprite register queue: default widths,
// collision flag width and the drain state encoding.
package sprite_register_queue_pkg;

    localparam int INDEX_WIDTH_DEFAULT = 12;
    localparam int DATA_WIDTH_DEFAULT  = 16;
    localparam int COLLISION_WIDTH     = 6;

    localparam logic [0:0] STATE_WAIT_VBLANK = 1'b0;
    localparam logic [0:0] STATE_DRAIN       = 1'b1;

endpackage

// File: rtl/sprite_register_queue_register_fifo.sv
// Synchronous FIFO of {index, value} register writes with a
// combinationally visible head entry and a registered occupancy count.
module register_fifo
    import sprite_register_queue_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEFAULT,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [INDEX_WIDTH-1:0]   push_index,
    input  logic [DATA_WIDTH-1:0]    push_value,
    input  logic                     pop,
    output logic [INDEX_WIDTH-1:0]   head_index,
    output logic [DATA_WIDTH-1:0]    head_value,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0]   COUNT_ONE  = {{PTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0]   COUNT_FULL = (PTR_WIDTH+1)'(DEPTH);

    logic [INDEX_WIDTH-1:0] index_mem [DEPTH];
    logic [DATA_WIDTH-1:0]  value_mem [DEPTH];
    logic [PTR_WIDTH-1:0]   write_ptr;
    logic [PTR_WIDTH-1:0]   read_ptr;

    assign full       = (count == COUNT_FULL);
    assign empty      = (count == '0);
    assign head_index = index_mem[read_ptr];
    assign head_value = value_mem[read_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            index_mem[write_ptr] <= push_index;
            value_mem[write_ptr] <= push_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                write_ptr <= write_ptr + PTR_ONE;
            end
            if (pop) begin
                read_ptr <= read_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sprite_register_queue.sv
// Queues CPU sprite register writes and replays them to the display
// controller during vertical blank; also keeps sticky collision flags.
module sprite_register_queue
    import sprite_register_queue_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEFAULT,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cpu_write_i,
    input  logic [INDEX_WIDTH-1:0]      cpu_index_i,
    input  logic [DATA_WIDTH-1:0]       cpu_value_i,
    output logic                        cpu_full_o,
    output logic [$clog2(DEPTH):0]      pending_o,
    output logic                        overflow_o,
    input  logic                        overflow_clear_i,
    input  logic                        in_vblank_i,
    output logic                        register_write_o,
    output logic [INDEX_WIDTH-1:0]      register_index_o,
    output logic [DATA_WIDTH-1:0]       register_write_value_o,
    input  logic [COLLISION_WIDTH-1:0]  collision_i,
    input  logic                        collision_read_i,
    output logic [COLLISION_WIDTH-1:0]  collision_o
);

    logic                   vblank_q;
    logic [0:0]             state;
    logic [0:0]             state_next;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   drop;
    logic                   pop;
    logic [INDEX_WIDTH-1:0] head_index;
    logic [DATA_WIDTH-1:0]  head_value;

    assign push       = cpu_write_i && !fifo_full;
    assign drop       = cpu_write_i && fifo_full;
    assign cpu_full_o = fifo_full;

    register_fifo #(
        .DEPTH       (DEPTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_index (cpu_index_i),
        .push_value (cpu_value_i),
        .pop        (pop),
        .head_index (head_index),
        .head_value (head_value),
        .count      (pending_o),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_next = state;
        case (state)
            STATE_WAIT_VBLANK: if (vblank_q)  state_next = STATE_DRAIN;
            STATE_DRAIN:       if (!vblank_q) state_next = STATE_WAIT_VBLANK;
            default:           state_next = STATE_WAIT_VBLANK;
        endcase
    end

    // Popping follows the state being entered so the first write lands two
    // cycles after vblank rises, and stops as soon as sampled vblank drops.
    assign pop = (state_next == STATE_DRAIN) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vblank_q               <= 1'b0;
            state                  <= STATE_WAIT_VBLANK;
            register_write_o       <= 1'b0;
            register_index_o       <= '0;
            register_write_value_o <= '0;
        end else begin
            vblank_q         <= in_vblank_i;
            state            <= state_next;
            register_write_o <= pop;
            if (pop) begin
                register_index_o       <= head_index;
                register_write_value_o <= head_value;
            end
        end
    end

    // A read clears the accumulated flags but keeps bits arriving that cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_o  <= 1'b0;
            collision_o <= '0;
        end else begin
            if (drop) begin
                overflow_o <= 1'b1;
            end else if (overflow_clear_i) begin
                overflow_o <= 1'b0;
            end
            if (collision_read_i) begin
                collision_o <= collision_i;
            end else begin
                collision_o <= collision_o | collision_i;
            end
        end
    end

endmodule

// File: tb/tb_sprite_register_queue.sv
// Directed self-checking bench for sprite_register_queue: a vector table for
// basic queue/drain/collision behaviour plus sequences for multi-cycle cases.
module tb_sprite_register_queue;

    logic        clk;
    logic        reset_n;
    logic        cpu_write_i;
    logic [11:0] cpu_index_i;
    logic [15:0] cpu_value_i;
    logic        cpu_full_o;
    logic [4:0]  pending_o;
    logic        overflow_o;
    logic        overflow_clear_i;
    logic        in_vblank_i;
    logic        register_write_o;
    logic [11:0] register_index_o;
    logic [15:0] register_write_value_o;
    logic [5:0]  collision_i;
    logic        collision_read_i;
    logic [5:0]  collision_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        write;
        logic [11:0] index;
        logic [15:0] value;
        logic        vblank;
        logic [5:0]  collision;
        logic        collision_read;
        logic        exp_write;
        logic [11:0] exp_index;
        logic [15:0] exp_value;
        logic [4:0]  exp_pending;
        logic [5:0]  exp_collision;
    } vector_t;

    vector_t vectors [15];

    sprite_register_queue #(
        .DEPTH       (16),
        .INDEX_WIDTH (12),
        .DATA_WIDTH  (16)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .cpu_write_i            (cpu_write_i),
        .cpu_index_i            (cpu_index_i),
        .cpu_value_i            (cpu_value_i),
        .cpu_full_o             (cpu_full_o),
        .pending_o              (pending_o),
        .overflow_o             (overflow_o),
        .overflow_clear_i       (overflow_clear_i),
        .in_vblank_i            (in_vblank_i),
        .register_write_o       (register_write_o),
        .register_index_o       (register_index_o),
        .register_write_value_o (register_write_value_o),
        .collision_i            (collision_i),
        .collision_read_i       (collision_read_i),
        .collision_o            (collision_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input vector_t v);
        cpu_write_i      = v.write;
        cpu_index_i      = v.index;
        cpu_value_i      = v.value;
        in_vblank_i      = v.vblank;
        collision_i      = v.collision;
        collision_read_i = v.collision_read;
        overflow_clear_i = 1'b0;
    endtask

    task automatic push_entry(input logic [11:0] index, input logic [15:0] value);
        cpu_write_i = 1'b1;
        cpu_index_i = index;
        cpu_value_i = value;
        tick();
        cpu_write_i = 1'b0;
    endtask

    int got_index[$];
    int window_count;

    initial begin
        // write idx value vb col rd | exp_wr exp_idx exp_val exp_pend exp_col
        vectors[0]  = '{1'b1, 12'h003, 16'd1, 1'b0, 6'b0, 1'b0, 1'b0, 12'h000, 16'd0, 5'd1, 6'b0};
        vectors[1]  = '{1'b1, 12'h007, 16'd2, 1'b0, 6'b0, 1'b0, 1'b0, 12'h000, 16'd0, 5'd2, 6'b0};
        vectors[2]  = '{1'b1, 12'h00B, 16'd3, 1'b0, 6'b0, 1'b0, 1'b0, 12'h000, 16'd0, 5'd3, 6'b0};
        vectors[3]  = '{1'b0, 12'h000, 16'd0, 1'b0, 6'b0, 1'b0, 1'b0, 12'h000, 16'd0, 5'd3, 6'b0};
        vectors[4]  = '{1'b0, 12'h000, 16'd0, 1'b1, 6'b0, 1'b0, 1'b0, 12'h000, 16'd0, 5'd3, 6'b0};
        vectors[5]  = '{1'b0, 12'h000, 16'd0, 1'b1, 6'b0, 1'b0, 1'b1, 12'h003, 16'd1, 5'd2, 6'b0};
        vectors[6]  = '{1'b0, 12'h000, 16'd0, 1'b1, 6'b0, 1'b0, 1'b1, 12'h007, 16'd2, 5'd1, 6'b0};
        vectors[7]  = '{1'b0, 12'h000, 16'd0, 1'b1, 6'b0, 1'b0, 1'b1, 12'h00B, 16'd3, 5'd0, 6'b0};
        vectors[8]  = '{1'b0, 12'h000, 16'd0, 1'b0, 6'b0, 1'b0, 1'b0, 12'h00B, 16'd3, 5'd0, 6'b0};
        vectors[9]  = '{1'b0, 12'h000, 16'd0, 1'b0, 6'b0, 1'b0, 1'b0, 12'h00B, 16'd3, 5'd0, 6'b0};
        vectors[10] = '{1'b0, 12'h000, 16'd0, 1'b0, 6'b000100, 1'b0, 1'b0, 12'h00B, 16'd3, 5'd0, 6'b000100};
        vectors[11] = '{1'b0, 12'h000, 16'd0, 1'b0, 6'b100000, 1'b0, 1'b0, 12'h00B, 16'd3, 5'd0, 6'b100100};
        vectors[12] = '{1'b0, 12'h000, 16'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 12'h00B, 16'd3, 5'd0, 6'b100100};
        vectors[13] = '{1'b0, 12'h000, 16'd0, 1'b0, 6'b000001, 1'b1, 1'b0, 12'h00B, 16'd3, 5'd0, 6'b000001};
        vectors[14] = '{1'b0, 12'h000, 16'd0, 1'b0, 6'b000000, 1'b0, 1'b0, 12'h00B, 16'd3, 5'd0, 6'b000001};

        reset_n          = 1'b0;
        cpu_write_i      = 1'b0;
        cpu_index_i      = '0;
        cpu_value_i      = '0;
        overflow_clear_i = 1'b0;
        in_vblank_i      = 1'b0;
        collision_i      = '0;
        collision_read_i = 1'b0;
        tick();
        tick();

        check_output("reset_pending", 32'(pending_o), 32'd0);
        check_output("reset_write", 32'(register_write_o), 32'd0);
        check_output("reset_index", 32'(register_index_o), 32'd0);
        check_output("reset_value", 32'(register_write_value_o), 32'd0);
        check_output("reset_overflow", 32'(overflow_o), 32'd0);
        check_output("reset_collision", 32'(collision_o), 32'd0);
        check_output("reset_full", 32'(cpu_full_o), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vectors[i]);
            tick();
            check_output($sformatf("vec%0d_write", i), 32'(register_write_o), 32'(vectors[i].exp_write));
            check_output($sformatf("vec%0d_pending", i), 32'(pending_o), 32'(vectors[i].exp_pending));
            check_output($sformatf("vec%0d_collision", i), 32'(collision_o), 32'(vectors[i].exp_collision));
            if (vectors[i].exp_write) begin
                check_output($sformatf("vec%0d_index", i), 32'(register_index_o), 32'(vectors[i].exp_index));
                check_output($sformatf("vec%0d_value", i), 32'(register_write_value_o), 32'(vectors[i].exp_value));
            end
        end
        collision_i      = '0;
        collision_read_i = 1'b0;
        in_vblank_i      = 1'b0;

        // Overflow: 16 accepted writes, the 17th dropped.
        for (int i = 0; i < 16; i++) begin
            push_entry(12'(i), 16'(i + 256));
            check_output($sformatf("fill%0d_pending", i), 32'(pending_o), 32'(i + 1));
            check_output($sformatf("fill%0d_full", i), 32'(cpu_full_o), 32'(i == 15));
        end
        check_output("fill_no_write", 32'(register_write_o), 32'd0);
        push_entry(12'h0FF, 16'hDEAD);
        check_output("drop_pending", 32'(pending_o), 32'd16);
        check_output("drop_overflow", 32'(overflow_o), 32'd1);
        tick();
        check_output("overflow_sticky", 32'(overflow_o), 32'd1);
        overflow_clear_i = 1'b1;
        push_entry(12'h0FE, 16'hBEEF);
        check_output("clear_vs_drop_overflow", 32'(overflow_o), 32'd1);
        check_output("clear_vs_drop_pending", 32'(pending_o), 32'd16);
        tick();
        check_output("overflow_cleared", 32'(overflow_o), 32'd0);
        overflow_clear_i = 1'b0;

        // Five-cycle vblank window over a full queue.
        got_index.delete();
        for (int t = 0; t < 8; t++) begin
            in_vblank_i = (t < 5);
            tick();
            if (register_write_o) begin
                got_index.push_back(int'(register_index_o));
                check_output("window_value", 32'(register_write_value_o), 32'(register_index_o) + 32'd256);
            end
        end
        window_count = got_index.size();
        check_output("window_count_in_range", 32'(window_count >= 1 && window_count <= 5), 32'd1);
        check_output("window_pending", 32'(pending_o), 32'(16 - window_count));

        // Remaining entries drain on the next vblank.
        for (int t = 0; t < 25; t++) begin
            in_vblank_i = 1'b1;
            tick();
            if (register_write_o) begin
                got_index.push_back(int'(register_index_o));
                check_output("drain2_value", 32'(register_write_value_o), 32'(register_index_o) + 32'd256);
            end
        end
        check_output("drain_total", 32'(got_index.size()), 32'd16);
        check_output("drain_pending", 32'(pending_o), 32'd0);
        for (int k = 0; k < got_index.size(); k++) begin
            check_output($sformatf("drain_order%0d", k), 32'(got_index[k]), 32'(k));
        end

        // Push into an empty queue during vblank: write two cycles later.
        push_entry(12'h055, 16'hABCD);
        check_output("vb_push_cycle1_write", 32'(register_write_o), 32'd0);
        tick();
        check_output("vb_push_cycle2_write", 32'(register_write_o), 32'd1);
        check_output("vb_push_index", 32'(register_index_o), 32'h055);
        check_output("vb_push_value", 32'(register_write_value_o), 32'hABCD);
        tick();
        check_output("vb_push_single_pulse", 32'(register_write_o), 32'd0);
        check_output("vb_push_hold_index", 32'(register_index_o), 32'h055);

        // Reset in the middle of a drain.
        in_vblank_i = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            push_entry(12'(16'h100 + i), 16'(i));
        end
        check_output("mid_fill_pending", 32'(pending_o), 32'd8);
        in_vblank_i = 1'b1;
        tick();
        check_output("mid_vblank_sampled_write", 32'(register_write_o), 32'd0);
        tick();
        check_output("mid_first_write", 32'(register_write_o), 32'd1);
        check_output("mid_first_pending", 32'(pending_o), 32'd7);
        tick();
        check_output("mid_second_pending", 32'(pending_o), 32'd6);
        reset_n = 1'b0;
        tick();
        check_output("mid_reset_pending", 32'(pending_o), 32'd0);
        check_output("mid_reset_write", 32'(register_write_o), 32'd0);
        check_output("mid_reset_index", 32'(register_index_o), 32'd0);
        reset_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check_output($sformatf("post_reset_write%0d", t), 32'(register_write_o), 32'd0);
            check_output($sformatf("post_reset_pending%0d", t), 32'(pending_o), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
